// File: rtl/car_light_pkg.sv
// Shared types and default timing constants for the tail-light turn-lever path.
package car_light_pkg;

   // Arbitration states for the left/right turn-lever request.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LEFT     = 2'd1,
      RIGHT    = 2'd2,
      CONFLICT = 2'd3
   } lever_state_t;

   // 20 ms debounce and 4 Hz step rate at a 1 MHz system clock.
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 20000;
   localparam int unsigned TICK_DIV_DEF        = 250000;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stable-count debounce filter for one raw contact.
module debounce_filter
   import car_light_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic            clean_q, clean_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count cycles of disagreement; accept the new level once the count reaches the limit.
   always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      if (sync2_q != clean_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
            clean_d = ~clean_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Synchronizer, counter and debounced level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clean = clean_q;

endmodule

// File: rtl/turn_lever_conditioner.sv
// Turn-lever input stage: debounces both levers, arbitrates them into exclusive
// left/right request levels and paces the light sequencer with step_tick.
module turn_lever_conditioner
   import car_light_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned TICK_DIV        = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic lever_left_raw,
   input  logic lever_right_raw,
   output logic left,
   output logic right,
   output logic step_tick,
   output logic conflict
);

   localparam int unsigned TickW = $clog2(TICK_DIV);

   logic             dl, dr;
   lever_state_t     state_q, state_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic             active_d;
   logic             left_q, right_q, conflict_q, tick_q;
   logic             tick_d;

   debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_left (
      .clk  (clk),
      .reset(reset),
      .raw  (lever_left_raw),
      .clean(dl)
   );

   debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_right (
      .clk  (clk),
      .reset(reset),
      .raw  (lever_right_raw),
      .clean(dr)
   );

   // First-come arbitration; every exit passes through IDLE so the sequencer sees a gap.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (dl && dr)       state_d = CONFLICT;
            else if (dl)        state_d = LEFT;
            else if (dr)        state_d = RIGHT;
         end
         LEFT:     if (!dl)         state_d = IDLE;
         RIGHT:    if (!dr)         state_d = IDLE;
         CONFLICT: if (!dl && !dr)  state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Prescaler restarts at 0 on entry to a request, so the first request cycle ticks.
   always_comb begin
      active_d   = (state_d == LEFT) || (state_d == RIGHT);
      tick_cnt_d = '0;
      if (active_d && (state_d == state_q)) begin
         if (tick_cnt_q == TickW'(TICK_DIV - 1)) tick_cnt_d = '0;
         else                                    tick_cnt_d = tick_cnt_q + TickW'(1);
      end
      tick_d = active_d && (tick_cnt_d == '0);
   end

   // State, prescaler and registered output decodes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         left_q     <= 1'b0;
         right_q    <= 1'b0;
         conflict_q <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         left_q     <= (state_d == LEFT);
         right_q    <= (state_d == RIGHT);
         conflict_q <= (state_d == CONFLICT);
         tick_q     <= tick_d;
      end
   end

   assign left      = left_q;
   assign right     = right_q;
   assign conflict  = conflict_q;
   assign step_tick = tick_q;

endmodule

// File: doc/turn_lever_conditioner.md
# turn_lever_conditioner

Input stage for the tail-light sequencer. Takes the raw, asynchronous left/right turn-lever contacts, synchronizes and debounces them, and arbitrates them into mutually exclusive `left`/`right` request levels. Generates the `step_tick` enable that paces the downstream light sequencer, replacing its free-running clock-divider bit with a single-clock-domain strobe.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable cycles required to accept a contact change (20 ms at 1 MHz); legal range ≥1.
- `TICK_DIV`, default 250000: `step_tick` period in cycles while a request is active (4 Hz at 1 MHz); legal range ≥2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `lever_left_raw` in 1: raw left contact, asynchronous, bouncy.
- `lever_right_raw` in 1: raw right contact, asynchronous, bouncy.
- `left` out 1: registered left request level to the sequencer.
- `right` out 1: registered right request level to the sequencer.
- `step_tick` out 1: one-cycle advance strobe for the sequencer.
- `conflict` out 1: high while both levers read as held.

## Operation
- Per input, a 2-flop synchronizer feeds the debounce filter.
- Debounce rule:
  - The counter increments while the synchronized value differs from the debounced value.
  - The counter clears on any cycle where they agree.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced value toggles and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Arbitration FSM on debounced `dl`/`dr`; states IDLE, LEFT, RIGHT, CONFLICT.
  - IDLE → LEFT if `dl & !dr`; → RIGHT if `dr & !dl`; → CONFLICT if `dl & dr`; else stay.
  - LEFT → IDLE when `!dl`. A rising `dr` while in LEFT is ignored; first-come wins.
  - RIGHT → IDLE when `!dr`. A rising `dl` while in RIGHT is ignored.
  - CONFLICT → IDLE only when `!dl & !dr`.
  - Every exit goes through IDLE for at least one cycle. The sequencer therefore always sees `left=right=0` between requests and returns to its off state.
- Outputs are registered decodes of state:
  - `left` = (state==LEFT)
  - `right` = (state==RIGHT)
  - `conflict` = (state==CONFLICT)
  - `left` and `right` are never both 1.
- Tick prescaler:
  - Counter width is `$clog2(TICK_DIV)`.
  - The counter is held at 0 in IDLE and CONFLICT.
  - In LEFT/RIGHT it counts 0…`TICK_DIV`-1 and wraps.
  - `step_tick` = 1 on the first cycle `left` or `right` is high, then on every wrap (period exactly `TICK_DIV`).
- `step_tick` is 0 in IDLE and CONFLICT. It is also 0 on the cycle a request drops, so no stale advance occurs.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - all sync flops, debounced values and counters to 0;
  - FSM to IDLE;
  - `left=right=step_tick=conflict=0`.
- Raw edge sampled at clock N, held clean:
  - debounced value changes at edge N+2+`DEBOUNCE_CYCLES`;
  - `left`/`right` change at edge N+3+`DEBOUNCE_CYCLES`.
- `step_tick` coincides with the first cycle of `left`/`right`. Subsequent ticks fall `TICK_DIV`, 2·`TICK_DIV`, … cycles later.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never reaches the outputs.
- Reset asserted mid-request drops all outputs immediately. After release the block re-qualifies levers from scratch, so a held lever reappears after the full latency.

## Structure
- Shared package `car_light_pkg`:
  - typedef `lever_state_t` (IDLE, LEFT, RIGHT, CONFLICT);
  - default constants `DEBOUNCE_CYCLES_DEF` and `TICK_DIV_DEF`.
- Sub-module `debounce_filter`, instantiated twice: synchronizer, counter, debounced flop; parameter `DEBOUNCE_CYCLES`.
- Top level holds the arbitration FSM, output decode and tick prescaler.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`, `TICK_DIV=8`.
- Reset with both levers low → all outputs 0. Hold left from clock 0 → `left` rises at clock 7 with `step_tick` at 7, 15, 23; `right` stays 0.
- Left toggles 1/0 every 2 cycles for 40 cycles → `left`, `right` and `step_tick` stay 0 throughout.
- Left held and active, then right pressed → `right` stays 0. Release left → `left` falls and one IDLE cycle follows; `right` rises the cycle after, with `step_tick` on its first cycle.
- Both levers pressed in the same cycle → `conflict`=1 at clock 7, `left=right=step_tick=0`. Release only right → still CONFLICT. Release both → IDLE.
- Right active, release right exactly one cycle before a tick is due → `right` falls and no `step_tick` is issued.
- Reset pulsed low for one cycle mid-request with left still held → outputs 0 immediately; `left` returns 7 cycles after reset release.
